// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 8N1 UART receiver with a first-word-fall-through byte FIFO
module uart_receiver #(
  parameter int BAUD_DIVISOR = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       serial_in,
  input  logic       rx_ready,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       fifo_full,
  output logic       rx_busy,
  output logic       frame_error,
  output logic       overrun
);

  localparam int CW = $clog2(BAUD_DIVISOR);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] HALF_LOAD = CW'(BAUD_DIVISOR / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(BAUD_DIVISOR - 1);
  localparam logic [AW:0]   DEPTH     = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_IDLE
  } state_t;

  state_t          r_state, w_state_next;
  logic            r_sync1, r_sync2;
  logic [CW-1:0]   r_baud_cnt, w_baud_cnt_next;
  logic [2:0]      r_bit_idx, w_bit_idx_next;
  logic [7:0]      r_shift, w_shift_next;
  logic            r_frame_error, r_overrun;
  logic            w_rx_s, w_tick, w_push_req, w_frame_err;

  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [AW:0]     r_count;
  logic            w_push, w_pop, w_drop;

  assign w_rx_s = r_sync2;
  assign w_tick = (r_baud_cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= serial_in;
      r_sync2 <= r_sync1;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_baud_cnt_next = w_tick ? '0 : r_baud_cnt - 1'b1;
    w_bit_idx_next  = r_bit_idx;
    w_shift_next    = r_shift;
    w_push_req      = 1'b0;
    w_frame_err     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_baud_cnt_next = '0;
        if (!w_rx_s) begin
          w_state_next    = S_START;
          w_baud_cnt_next = HALF_LOAD;
        end
      end
      S_START: begin
        if (w_tick) begin
          if (!w_rx_s) begin
            w_state_next    = S_DATA;
            w_baud_cnt_next = FULL_LOAD;
            w_bit_idx_next  = 3'd0;
          end else begin
            w_state_next = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (w_tick) begin
          w_shift_next[r_bit_idx] = w_rx_s;
          w_baud_cnt_next         = FULL_LOAD;
          w_bit_idx_next          = r_bit_idx + 3'd1;
          if (r_bit_idx == 3'd7) w_state_next = S_STOP;
        end
      end
      S_STOP: begin
        if (w_tick) begin
          if (w_rx_s) begin
            w_push_req   = 1'b1;
            w_state_next = S_IDLE;
          end else begin
            w_frame_err  = 1'b1;
            w_state_next = S_WAIT_IDLE;
          end
        end
      end
      S_WAIT_IDLE: begin
        // Hold here through a break so a long low line cannot retrigger a start
        w_baud_cnt_next = '0;
        if (w_rx_s) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_baud_cnt    <= '0;
      r_bit_idx     <= 3'd0;
      r_shift       <= 8'h00;
      r_frame_error <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_baud_cnt    <= w_baud_cnt_next;
      r_bit_idx     <= w_bit_idx_next;
      r_shift       <= w_shift_next;
      r_frame_error <= w_frame_err;
      r_overrun     <= w_drop;
    end
  end

  // A full FIFO still accepts a byte when the consumer pops in the same cycle
  assign w_pop  = data_valid & rx_ready;
  assign w_push = w_push_req & (~fifo_full | w_pop);
  assign w_drop = w_push_req & fifo_full & ~w_pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= r_shift;
  end

  assign data_valid  = (r_count != '0);
  assign fifo_full   = (r_count == DEPTH);
  assign data_out    = data_valid ? r_mem[r_rd_ptr] : 8'h00;
  assign rx_busy     = (r_state != S_IDLE);
  assign frame_error = r_frame_error;
  assign overrun     = r_overrun;

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
Serial-to-parallel UART receiver. It recovers 8N1 frames (1 start, 8 data LSB-first, 1 stop) from an asynchronous serial line and buffers received bytes in a small first-word-fall-through FIFO. It is the receive-side counterpart of uart_transmitter and uses the same BAUD_DIVISOR clocks-per-bit convention, so a looped-back transmitter/receiver pair with equal divisors interoperates. All logic runs on one clock.

Parameters:
BAUD_DIVISOR, 434, clocks per bit period (50 MHz / 115200); minimum 4.
FIFO_DEPTH, 4, receive FIFO entries; power of two, minimum 2.

Ports:
clk  input  1  system clock; all logic on the rising edge.
rst  input  1  synchronous, active-high reset.
serial_in  input  1  asynchronous serial line; idles high.
rx_ready  input  1  consumer accepts data_out this cycle when data_valid=1.
data_out  output  8  FIFO head byte; valid only while data_valid=1.
data_valid  output  1  FIFO non-empty.
fifo_full  output  1  FIFO holds FIFO_DEPTH entries.
rx_busy  output  1  FSM is not in IDLE.
frame_error  output  1  one-cycle pulse when the stop bit is sampled low.
overrun  output  1  one-cycle pulse when a good byte is dropped because the FIFO is full.

Behaviour:
- Reset values:
  - data_valid=0, fifo_full=0, rx_busy=0, frame_error=0, overrun=0, data_out=0.
  - FIFO pointers and count are 0.
  - Both synchronizer flops are 1.
  - FSM is in IDLE.
  - Bit counter and baud counter are 0.
- Reset mid-frame aborts the frame and discards FIFO contents.
- Input path: serial_in passes through a 2-flop synchronizer; rx_s is the second flop. All sampling uses rx_s.
- Baud counter: loaded, then decremented each clock; "tick" occurs when it equals 0.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
- IDLE:
  - On rx_s=0, go to START and load the counter with BAUD_DIVISOR/2 - 1 (integer divide).
- START: on tick, sample rx_s.
  - rx_s=0: go to DATA, load the counter with BAUD_DIVISOR-1, clear the bit index.
  - rx_s=1: false start; return to IDLE with no output activity.
- DATA:
  - On each tick, shift rx_s into shift_reg[bit_index] (LSB first) and reload the counter with BAUD_DIVISOR-1.
  - After bit 7 is sampled, go to STOP.
- STOP: on tick, sample rx_s.
  - rx_s=1: request a FIFO push of shift_reg and go to IDLE.
  - rx_s=0: pulse frame_error, discard the byte, go to WAIT_IDLE.
- WAIT_IDLE: stay until rx_s=1, then go to IDLE. This prevents a break condition from retriggering start detection.
- rx_busy is 1 in every state except IDLE.
- FIFO push/pop rules:
  - Push is accepted when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
  - Otherwise the byte is dropped and overrun pulses for exactly that cycle.
  - Pop happens when data_valid & rx_ready.
  - Simultaneous push and pop leaves the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Output timing:
  - data_out/data_valid are driven combinationally from FIFO head and count.
  - A byte pushed at clock edge N is visible (data_valid=1) after edge N.
  - Pop with rx_ready=1 at edge N presents the next entry, or drops data_valid, after edge N.
  - rx_ready while data_valid=0 is ignored.
- Latency: from the serial_in falling edge to data_valid is ~9.5 bit periods plus 2-3 clocks of synchronizer delay.
- Error flags:
  - frame_error and overrun are registered single-cycle pulses; they are never asserted together.
  - Neither flag affects FIFO contents already stored.

Test Plan:
1. BAUD_DIVISOR=16. After reset hold serial_in=1 for 100 clocks, then drive frame 0x55 (0,1,0,1,0,1,0,1,0,1 at 16 clocks/bit) -> data_valid rises within 3 clocks after the stop-bit midpoint, data_out=0x55. Pulse rx_ready -> data_valid=0 next cycle.
2. Back-to-back frames 0xA5, 0x00, 0xFF, 0x3C with rx_ready=0 -> fifo_full=1 after the 4th byte. Then pop 4 times -> bytes come out in order 0xA5, 0x00, 0xFF, 0x3C, and pointer wrap is exercised.
3. With the FIFO full (rx_ready=0), send a 5th frame 0x81 -> overrun pulses for 1 cycle, FIFO contents unchanged. Repeat with rx_ready=1 on the push cycle -> no overrun, 0x81 accepted.
4. Send frame 0x12 with the stop bit driven 0, hold line low 40 clocks, then high -> frame_error pulses once, no push, rx_busy stays 1 until the line returns high. A following 0x34 frame is received correctly.
5. Glitch serial_in low for 3 clocks (< BAUD_DIVISOR/2) -> FSM returns to IDLE, no push, no error pulses.
6. Assert rst for 1 cycle during DATA bit 4 of a frame, with 2 bytes already buffered -> all outputs return to reset values next cycle. A complete frame sent after the line idles is received as the only FIFO entry.
